// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: arbitrates left/right/hazard turn-signal requests against
// the vehicle state and drives both lamps from one shared blink timebase, so
// the lamps always flash in phase.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   car_state    vehicle state code (steady / normal / off classes)
//   left_req     left direction switch, level
//   right_req    right direction switch, level
//   hazard       hazard switch, level
//   left_light   left lamp drive, registered
//   right_light  right lamp drive, registered
//   mode         current FSM state encoding, registered
module turn_signal_ctrl #(
  parameter int unsigned HALF_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] car_state,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard,
  output logic       left_light,
  output logic       right_light,
  output logic [2:0] mode
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_STEADY = 3'd1,
    ST_IDLE   = 3'd2,
    ST_LEFT   = 3'd3,
    ST_RIGHT  = 3'd4,
    ST_HAZARD = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             prev_left_q, prev_right_q;
  logic             left_q, left_d;
  logic             right_q, right_d;

  logic rise_l, rise_r;
  logic blink_d, entry;

  assign rise_l = left_req & ~prev_left_q;
  assign rise_r = right_req & ~prev_right_q;

  // Next-state arbitration: vehicle class first, then hazard, then direction.
  always_comb begin
    state_d = ST_IDLE;
    case (car_state)
      3'b000, 3'b001, 3'b010: state_d = ST_STEADY;
      3'b011, 3'b100: begin
        if (hazard) begin
          state_d = ST_HAZARD;
        end else if (left_req && !right_req) begin
          state_d = ST_LEFT;
        end else if (right_req && !left_req) begin
          state_d = ST_RIGHT;
        end else if (!left_req && !right_req) begin
          state_d = ST_IDLE;
        end else if (rise_l && !rise_r) begin
          // Both held: the most recent switch wins.
          state_d = ST_LEFT;
        end else if (rise_r && !rise_l) begin
          state_d = ST_RIGHT;
        end else if (!rise_l && !rise_r &&
                     (state_q == ST_LEFT || state_q == ST_RIGHT)) begin
          state_d = state_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Blink timebase and lamp decode, computed from the next state so the
  // lamps are on starting at the entry edge.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    blink_d = (state_d == ST_LEFT) || (state_d == ST_RIGHT) ||
              (state_d == ST_HAZARD);
    entry   = blink_d && (state_d != state_q);

    if (entry) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (blink_d) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end

    case (state_d)
      ST_STEADY: begin
        left_d  = 1'b1;
        right_d = 1'b1;
      end
      ST_LEFT:   left_d  = phase_d;
      ST_RIGHT:  right_d = phase_d;
      ST_HAZARD: begin
        left_d  = phase_d;
        right_d = phase_d;
      end
      default: begin
        left_d  = 1'b0;
        right_d = 1'b0;
      end
    endcase
  end

  // FSM, timebase, edge-detect and lamp registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      prev_left_q  <= 1'b0;
      prev_right_q <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      prev_left_q  <= left_req;
      prev_right_q <= right_req;
      left_q       <= left_d;
      right_q      <= right_d;
    end
  end

  assign left_light  = left_q;
  assign right_light = right_q;
  assign mode        = 3'(state_q);

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Sequences the two turn-signal lamps of the car model from the vehicle state, the left/right direction switches and the hazard switch. It arbitrates competing lamp requests and owns the single blink timebase shared by both lamps, so the left and right lamps always flash in phase. It sits between the vehicle state machine and the lamp/LED outputs, and replaces per-lamp flashing logic.

## Interface
- HALF_PERIOD, 50_000_000: clock cycles per lamp half-period (on time = off time); must be ≥ 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- car_state  input  3  vehicle state code from the vehicle FSM.
- left_req  input  1  left direction switch, level; synchronous and debounced upstream.
- right_req  input  1  right direction switch, level; synchronous and debounced upstream.
- hazard  input  1  hazard switch, level; synchronous.
- left_light  output  1  left lamp drive, registered.
- right_light  output  1  right lamp drive, registered.
- mode  output  3  current FSM state encoding, registered, for display and debug.

## Operation
- FSM states and mode encoding: OFF=0, STEADY=1, IDLE=2, LEFT=3, RIGHT=4, HAZARD=5.
- car_state classes:
  - 000, 001, 010 → steady class.
  - 011, 100 → normal class.
  - 101–111 → off class.
- Next-state priority, evaluated every cycle:
  1. Steady class → STEADY.
  2. Off class → OFF.
  3. Normal class with hazard=1 → HAZARD.
  4. Normal class, only left_req=1 → LEFT.
  5. Normal class, only right_req=1 → RIGHT.
  6. Normal class, neither request → IDLE.
  7. Normal class, both requests high: last request wins.
     - Rising edge on left_req only → LEFT.
     - Rising edge on right_req only → RIGHT.
     - Both rising in the same cycle → IDLE.
     - No rising edge → hold the current state if it is LEFT or RIGHT; otherwise IDLE.
- Rising edges are detected against prev_left and prev_right registers, which update every non-reset cycle.
- Blink timebase:
  - Counter `cnt`, width clog2(HALF_PERIOD); one-bit `phase`.
  - On entry into LEFT, RIGHT or HAZARD from any other state (including LEFT↔RIGHT switches and HAZARD→LEFT/RIGHT): cnt=0, phase=1.
  - While staying in a blink state: cnt increments. When cnt==HALF_PERIOD-1, cnt wraps to 0 and phase toggles.
  - In any non-blink state: cnt=0, phase=0.
- Lamp outputs:
  - OFF, IDLE: both lamps 0.
  - STEADY: both lamps 1.
  - LEFT: left_light=phase, right_light=0.
  - RIGHT: left_light=0, right_light=phase.
  - HAZARD: both lamps = phase.

## Timing
- Reset (rst_n=0 at a rising edge) forces the following, regardless of other inputs:
  - state=OFF, mode=0.
  - left_light=0, right_light=0.
  - cnt=0, phase=0.
  - prev_left=0, prev_right=0.
- A switch held through reset counts as a rising edge on the first cycle after reset.
- Latency: inputs sampled at edge k → state, mode and lamps reflect them immediately after edge k. This is one cycle, with no combinational input-to-output path.
- Blink entry: the lamp is on from the entry edge for exactly HALF_PERIOD cycles, then off for HALF_PERIOD cycles, repeating. Full blink period = 2·HALF_PERIOD cycles.
- Re-entering the same blink state after leaving it for ≥1 cycle restarts the blink at phase=1.
- Timebase wrap: cnt never exceeds HALF_PERIOD-1, and the toggle and wrap happen on the same edge.
- Reset mid-blink: lamps go to 0 at that edge. There is no carry-over of cnt or phase.
- A car_state change from normal to steady/off class mid-blink takes effect at the next edge, overriding all requests.

## Test plan
- HALF_PERIOD=4, reset for 3 cycles with all switches high, car_state=011 → during reset lamps 0, mode=0. First edge after release: mode=5, both lamps 1 for 4 cycles, then 0 for 4 cycles, repeating.
- car_state=011, left_req 0→1 → mode=3 after the sampling edge. left_light=1 for 4 cycles, then 0 for 4, with right_light=0 throughout. Dropping left_req → mode=2 and both lamps 0 after the next edge.
- Left held and blinking, right_req rises → mode=4 next edge with right_light=1, left_light=0 (phase restarted).
  - Then left_req falls and rises again → mode=3.
  - Then both switches low, and both rise in the same cycle → mode=2.
- Hazard mid-LEFT at cnt=2 → mode=5, both lamps 1 for a full 4 cycles. Releasing hazard with left still high → mode=3, phase restarted at 1.
- car_state sweep with left_req=1:
  - 000/001/010 → mode=1, both lamps steady 1.
  - 101/110/111 → mode=0, both lamps 0.
  - 100 → mode=3, blinking.
- rst_n pulsed low for one cycle mid-RIGHT at phase=1 → lamps 0 and mode=0 at that edge. With right_req still high, the next edge gives mode=4, right_light=1, cnt=0.
